dmem_arbiter: RTL
=================

# dmem_arbiter

Arbiter and sequencer for the single-port data RAM shared by the ARM pipeline's data port and the camera capture path. Camera pixels are packed into 32-bit words. Each full word is written into a circular frame buffer whenever the CPU leaves a memory slot free. A starvation counter forces a camera slot, stalling the pipeline for one cycle, when the CPU monopolises the RAM for too long. The block sits between `arm` (data port), the camera pixel source and the `ram` instance.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width.
- `PIX_W`, 8: pixel width. Must divide 32; pixels per word `PPW = 32/PIX_W`.
- `FRAME_BASE`, 'h100: first RAM word address of the frame buffer.
- `FRAME_WORDS`, 64: frame buffer length in words, ≥ 2.
- `STARVE_MAX`, 4: waiting cycles after which the camera is forced a slot, ≥ 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cpu_write_enable`, in, 1: CPU store this cycle.
- `cpu_read_enable`, in, 1: CPU load this cycle.
- `cpu_address`, in, 32: CPU word address; bits [ADDR_W-1:0] are used.
- `cpu_write_data`, in, 32: store data.
- `cpu_read_data`, out, 32: load data, equal to `ram_q`.
- `cpu_stall`, out, 1: CPU access not serviced this cycle; CPU holds its request.
- `cam_valid`, in, 1: pixel available.
- `cam_ready`, out, 1: pixel accepted when `cam_valid` and `cam_ready` are both high.
- `cam_pixel`, in, PIX_W: pixel data.
- `cam_frame_start`, in, 1: restart the frame at word 0.
- `frame_done`, out, 1: one-cycle pulse after the last frame word is written.
- `ram_address`, out, ADDR_W: RAM address.
- `ram_write_data`, out, 32: RAM write data.
- `ram_wren`, out, 1: RAM write enable.
- `ram_q`, in, 32: RAM registered read data, one-cycle latency.

## Operation
- Packer:
  - `pack_buf` (32 bits), `pix_cnt` (0..PPW-1), `word_pending` flag.
  - `cam_ready = !word_pending`.
  - An accepted pixel is stored at bits [pix_cnt*PIX_W +: PIX_W], so the first pixel lands in the LSBs.
  - The PPW-th accepted pixel sets `word_pending` and resets `pix_cnt` to 0.
- Requests:
  - `cpu_req = cpu_write_enable | cpu_read_enable`.
  - `cam_req = word_pending`.
- Grant (combinational from the current inputs and registered state):
  - `!cam_req`: CPU owns the RAM.
  - `cam_req & !cpu_req`: camera owns the RAM.
  - `cam_req & cpu_req & wait_cnt < STARVE_MAX`: CPU owns the RAM.
  - `cam_req & cpu_req & wait_cnt == STARVE_MAX`: camera owns the RAM and `cpu_stall = 1`.
- RAM muxing:
  - CPU grant: `ram_address = cpu_address[ADDR_W-1:0]`, `ram_write_data = cpu_write_data`, `ram_wren = cpu_write_enable`.
  - Camera grant: `ram_address = FRAME_BASE + word_idx`, `ram_write_data = pack_buf`, `ram_wren = 1`. This clears `word_pending` at the clock edge.
- `wait_cnt`:
  - Increments each cycle `cam_req` is pending and not granted, saturating at STARVE_MAX.
  - Clears on a camera grant.
- `word_idx`:
  - Increments after each camera write.
  - The write at `FRAME_WORDS-1` wraps `word_idx` to 0 and pulses `frame_done` the next cycle.
- `cam_frame_start`:
  - Synchronous.
  - Clears `pix_cnt`, `word_idx`, `word_pending` and `wait_cnt`; a partial or pending word is discarded.
  - Pixels presented in the same cycle are not accepted (`cam_ready` is forced to 0).
  - It has priority over a camera grant in the same cycle; that write is suppressed.
- The pipeline has no load/store stall from any other source; the CPU must honour `cpu_stall` by holding its address, data and enables.

## Timing
- Reset values:
  - Registers: `pack_buf=0`, `pix_cnt=0`, `word_pending=0`, `wait_cnt=0`, `word_idx=0`.
  - Outputs: `frame_done=0`, `ram_wren=0` (no CPU write asserted), `cpu_stall=0`, `cam_ready=1` (once reset is released).
- Reset mid-frame discards all buffered pixels.
- Pixel to pending: the PPW-th pixel is accepted at edge N and `word_pending=1` from cycle N+1. The word can be written in cycle N+1 at the earliest.
- Worst-case camera latency from pending to write is STARVE_MAX+1 cycles.
- Load data: `cpu_read_data` is valid the cycle after a non-stalled read cycle.
- `cpu_stall` and `cam_ready` are combinational; there are no registered grants.
- Full-buffer back-pressure: while `word_pending=1`, `cam_ready=0`. The next pixel is accepted in the cycle after the write.

## Test plan
Parameters for all scenarios: PIX_W=8, FRAME_BASE='h100, FRAME_WORDS=4, STARVE_MAX=3.

1. Idle CPU, pixels 'h11,'h22,'h33,'h44 on consecutive cycles -> `ram_wren=1`, `ram_address='h100`, `ram_write_data='h44332211` in the following cycle; `cam_ready=0` for exactly that cycle.
2. CPU continuous stores to address 5 while a word is pending -> CPU is served for 3 cycles. The 4th cycle writes the camera word with `cpu_stall=1`. The next cycle writes CPU data 5 with `cpu_stall=0`.
3. CPU load from address 5 after storing 'hCAFE0001 -> `cpu_read_data='hCAFE0001` one cycle after the non-stalled read.
4. 16 pixels with the CPU idle -> words written to 'h100..'h103; `frame_done` pulses once after the 'h103 write; the 17th–20th pixels go to 'h100 (wrap).
5. `cam_frame_start` after 2 pixels, then 4 pixels 'hA1..'hA4 -> single write 'hA4A3A2A1 at 'h100; the earlier pixels never reach RAM.
6. Reset asserted with a word pending and `wait_cnt=2` -> no write occurs, all outputs at reset values, `cam_ready=1` after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and the camera packer.
// The CPU wins by default; a pending camera word takes a slot once it has waited STARVE_MAX cycles.
module dmem_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int PIX_W       = 8,
   parameter int FRAME_BASE  = 'h100,
   parameter int FRAME_WORDS = 64,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_write_enable,
   input  logic              cpu_read_enable,
   input  logic [31:0]       cpu_address,
   input  logic [31:0]       cpu_write_data,
   output logic [31:0]       cpu_read_data,
   output logic              cpu_stall,
   input  logic              cam_valid,
   output logic              cam_ready,
   input  logic [PIX_W-1:0]  cam_pixel,
   input  logic              cam_frame_start,
   output logic              frame_done,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_write_data,
   output logic              ram_wren,
   input  logic [31:0]       ram_q
);

   localparam int PPW  = 32 / PIX_W;
   localparam int PC_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int WI_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int WC_W = $clog2(STARVE_MAX + 1);

   logic [31:0]     pack_buf_q, pack_buf_d;
   logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;
   logic            word_pending_q, word_pending_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [WI_W-1:0] word_idx_q, word_idx_d;
   logic            frame_done_q, frame_done_d;

   logic cpu_req, cam_req, cam_grant, pix_accept, last_word, starved;
   logic unused_addr_hi;

   assign unused_addr_hi = ^cpu_address[31:ADDR_W];

   assign cpu_req    = cpu_write_enable | cpu_read_enable;
   assign cam_req    = word_pending_q;
   assign starved    = (wait_cnt_q == WC_W'(STARVE_MAX));
   assign cam_ready  = ~word_pending_q & ~cam_frame_start;
   assign pix_accept = cam_valid & cam_ready;
   // A frame restart discards the pending word, so it must not also be written.
   assign cam_grant  = cam_req & ~cam_frame_start & (~cpu_req | starved);
   assign cpu_stall  = cam_grant & cpu_req;
   assign last_word  = (word_idx_q == WI_W'(FRAME_WORDS - 1));

   assign ram_address    = cam_grant ? (ADDR_W'(FRAME_BASE) + ADDR_W'(word_idx_q))
                                     : cpu_address[ADDR_W-1:0];
   assign ram_write_data = cam_grant ? pack_buf_q : cpu_write_data;
   assign ram_wren       = cam_grant | cpu_write_enable;
   assign cpu_read_data  = ram_q;
   assign frame_done     = frame_done_q;

   always_comb begin
      pack_buf_d     = pack_buf_q;
      pix_cnt_d      = pix_cnt_q;
      word_pending_d = word_pending_q;
      wait_cnt_d     = wait_cnt_q;
      word_idx_d     = word_idx_q;
      frame_done_d   = 1'b0;
      if (cam_frame_start) begin
         pix_cnt_d      = '0;
         word_idx_d     = '0;
         word_pending_d = 1'b0;
         wait_cnt_d     = '0;
      end else begin
         if (pix_accept) begin
            for (int i = 0; i < PPW; i++) begin
               if (pix_cnt_q == PC_W'(i)) pack_buf_d[i*PIX_W +: PIX_W] = cam_pixel;
            end
            if (pix_cnt_q == PC_W'(PPW - 1)) begin
               pix_cnt_d      = '0;
               word_pending_d = 1'b1;
            end else begin
               pix_cnt_d = pix_cnt_q + PC_W'(1);
            end
         end
         if (cam_grant) begin
            word_pending_d = 1'b0;
            wait_cnt_d     = '0;
            frame_done_d   = last_word;
            word_idx_d     = last_word ? '0 : word_idx_q + WI_W'(1);
         end else if (cam_req && !starved) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pack_buf_q     <= '0;
         pix_cnt_q      <= '0;
         word_pending_q <= 1'b0;
         wait_cnt_q     <= '0;
         word_idx_q     <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         pack_buf_q     <= pack_buf_d;
         pix_cnt_q      <= pix_cnt_d;
         word_pending_q <= word_pending_d;
         wait_cnt_q     <= wait_cnt_d;
         word_idx_q     <= word_idx_d;
         frame_done_q   <= frame_done_d;
      end
   end

endmodule
